// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 Set-2 scan-code decoder.
//   ps2_dec_state_t : decoder FSM state encoding
//   PS2_*           : prefix bytes, modifier scan codes, Pause sequence length
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    PAUSE   = 3'd4
  } ps2_dec_state_t;

  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam logic [7:0] PS2_BRK       = 8'hF0;
  localparam logic [7:0] PS2_PAUSE     = 8'hE1;
  localparam logic [7:0] PS2_LSHIFT    = 8'h12;
  localparam logic [7:0] PS2_RSHIFT    = 8'h59;
  localparam logic [7:0] PS2_CAPS      = 8'h58;
  localparam logic [3:0] PS2_PAUSE_LEN = 4'd7;

endpackage

// File: rtl/ps2_ascii_lut.sv
// ps2_ascii_lut: combinational Set-2 scan code to ASCII lookup.
//   code  in  8 : base scan code (prefixes already stripped)
//   upper in  1 : letter case select (shift XOR caps)
//   shift in  1 : selects shifted symbol for digits/punctuation
//   ascii out 8 : ASCII character, 0 when the code is unmapped
module ps2_ascii_lut
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       upper,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] plain_s;
  logic [7:0] shifted_s;
  logic       letter_s;

  // Base and shifted character per scan code; letters only need the lower-case form.
  always_comb begin
    plain_s   = 8'h00;
    shifted_s = 8'h00;
    case (code)
      8'h1C: plain_s = 8'h61;  8'h32: plain_s = 8'h62;  8'h21: plain_s = 8'h63;
      8'h23: plain_s = 8'h64;  8'h24: plain_s = 8'h65;  8'h2B: plain_s = 8'h66;
      8'h34: plain_s = 8'h67;  8'h33: plain_s = 8'h68;  8'h43: plain_s = 8'h69;
      8'h3B: plain_s = 8'h6A;  8'h42: plain_s = 8'h6B;  8'h4B: plain_s = 8'h6C;
      8'h3A: plain_s = 8'h6D;  8'h31: plain_s = 8'h6E;  8'h44: plain_s = 8'h6F;
      8'h4D: plain_s = 8'h70;  8'h15: plain_s = 8'h71;  8'h2D: plain_s = 8'h72;
      8'h1B: plain_s = 8'h73;  8'h2C: plain_s = 8'h74;  8'h3C: plain_s = 8'h75;
      8'h2A: plain_s = 8'h76;  8'h1D: plain_s = 8'h77;  8'h22: plain_s = 8'h78;
      8'h35: plain_s = 8'h79;  8'h1A: plain_s = 8'h7A;
      8'h16: begin plain_s = 8'h31; shifted_s = 8'h21; end
      8'h1E: begin plain_s = 8'h32; shifted_s = 8'h40; end
      8'h26: begin plain_s = 8'h33; shifted_s = 8'h23; end
      8'h25: begin plain_s = 8'h34; shifted_s = 8'h24; end
      8'h2E: begin plain_s = 8'h35; shifted_s = 8'h25; end
      8'h36: begin plain_s = 8'h36; shifted_s = 8'h5E; end
      8'h3D: begin plain_s = 8'h37; shifted_s = 8'h26; end
      8'h3E: begin plain_s = 8'h38; shifted_s = 8'h2A; end
      8'h46: begin plain_s = 8'h39; shifted_s = 8'h28; end
      8'h45: begin plain_s = 8'h30; shifted_s = 8'h29; end
      8'h4E: begin plain_s = 8'h2D; shifted_s = 8'h5F; end
      8'h55: begin plain_s = 8'h3D; shifted_s = 8'h2B; end
      8'h41: begin plain_s = 8'h2C; shifted_s = 8'h3C; end
      8'h49: begin plain_s = 8'h2E; shifted_s = 8'h3E; end
      8'h4A: begin plain_s = 8'h2F; shifted_s = 8'h3F; end
      8'h4C: begin plain_s = 8'h3B; shifted_s = 8'h3A; end
      8'h29: begin plain_s = 8'h20; shifted_s = 8'h20; end
      8'h5A: begin plain_s = 8'h0D; shifted_s = 8'h0D; end
      default: begin plain_s = 8'h00; shifted_s = 8'h00; end
    endcase
  end

  assign letter_s = (plain_s >= 8'h61) && (plain_s <= 8'h7A);

  // Letters follow shift^caps, everything else follows shift alone.
  always_comb begin
    if (letter_s) begin
      ascii = upper ? (plain_s - 8'h20) : plain_s;
    end else begin
      ascii = shift ? shifted_s : plain_s;
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: turns PS/2 Set-2 byte sequences into single key events.
//   clk, reset          : system clock, synchronous active-high reset
//   code_valid, code    : one-cycle strobe with a received scan-code byte
//   key_valid           : one-cycle strobe, event fields below are valid
//   key_code            : base scan code, prefixes stripped
//   key_extended        : event carried the E0 prefix
//   key_release         : break event
//   shift, caps         : modifier levels
//   ascii               : ASCII of the event (0 if none)
//   err                 : one-cycle protocol error strobe
// Build option: define PS2_ASCII_EN to enable the ASCII lookup; otherwise ascii is 0.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int DROP_REPEAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] code,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release,
  output logic       shift,
  output logic       caps,
  output logic [7:0] ascii,
  output logic       err
);

  ps2_dec_state_t state_r, state_next_s;
  logic [2:0] pause_cnt_r, pause_cnt_next_s;
  logic       ev_s, ev_ext_s, ev_rel_s, err_s;
  logic [7:0] ev_code_s;
  logic [9:0] held_r, held_next_s;
  logic       held_hit_s, emit_s;
  logic       lshift_r, rshift_r, lshift_next_s, rshift_next_s;
  logic       shift_next_s, caps_next_s;
  logic [7:0] lut_ascii_s, ascii_next_s;
  logic       key_valid_r, key_ext_r, key_rel_r, shift_r, caps_r, err_r;
  logic [7:0] key_code_r, ascii_r;

  // FSM state and Pause byte counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      pause_cnt_r <= 3'd0;
    end else begin
      state_r     <= state_next_s;
      pause_cnt_r <= pause_cnt_next_s;
    end
  end

  // Next state plus the candidate event decoded from the current byte.
  always_comb begin
    state_next_s     = state_r;
    pause_cnt_next_s = pause_cnt_r;
    ev_s             = 1'b0;
    ev_ext_s         = 1'b0;
    ev_rel_s         = 1'b0;
    ev_code_s        = code;
    err_s            = 1'b0;
    if (code_valid) begin
      if ((code == 8'h00) || (code == 8'hFF)) begin
        err_s        = 1'b1;
        state_next_s = IDLE;
      end else begin
        case (state_r)
          IDLE: begin
            if (code == PS2_EXT) begin
              state_next_s = EXT;
            end else if (code == PS2_BRK) begin
              state_next_s = BRK;
            end else if (code == PS2_PAUSE) begin
              state_next_s     = PAUSE;
              pause_cnt_next_s = 3'd0;
            end else begin
              ev_s = 1'b1;
            end
          end
          EXT: begin
            if (code == PS2_BRK) begin
              state_next_s = EXT_BRK;
            end else if (code == PS2_EXT) begin
              state_next_s = EXT;
            end else begin
              ev_s         = 1'b1;
              ev_ext_s     = 1'b1;
              state_next_s = IDLE;
            end
          end
          BRK, EXT_BRK: begin
            if (code == PS2_BRK) begin
              state_next_s = state_r;
            end else if (code == PS2_EXT) begin
              err_s        = 1'b1;
              state_next_s = IDLE;
            end else begin
              ev_s         = 1'b1;
              ev_rel_s     = 1'b1;
              ev_ext_s     = (state_r == EXT_BRK);
              state_next_s = IDLE;
            end
          end
          PAUSE: begin
            // Trailing bytes are swallowed; the last one produces the Pause make.
            if ({1'b0, pause_cnt_r} == (PS2_PAUSE_LEN - 4'd1)) begin
              ev_s             = 1'b1;
              ev_code_s        = PS2_PAUSE;
              pause_cnt_next_s = 3'd0;
              state_next_s     = IDLE;
            end else begin
              pause_cnt_next_s = pause_cnt_r + 3'd1;
            end
          end
          default: state_next_s = IDLE;
        endcase
      end
    end else begin
      state_next_s = state_r;
    end
  end

  assign held_hit_s = (held_r == {1'b1, ev_ext_s, ev_code_s});

  // Repeat filter, held-key tracking and modifier updates.
  always_comb begin
    emit_s        = ev_s;
    held_next_s   = held_r;
    lshift_next_s = lshift_r;
    rshift_next_s = rshift_r;
    caps_next_s   = caps_r;
    if (DROP_REPEAT != 0) begin
      if (ev_s && !ev_rel_s && held_hit_s) begin
        emit_s = 1'b0;
      end else if (ev_s && !ev_rel_s) begin
        held_next_s = {1'b1, ev_ext_s, ev_code_s};
      end else if (ev_s && held_hit_s) begin
        held_next_s = 10'd0;
      end else begin
        held_next_s = held_r;
      end
    end else begin
      held_next_s = 10'd0;
    end
    // Extended 12 is the print-screen fake shift and is ignored here.
    if (emit_s && !ev_ext_s) begin
      if (ev_code_s == PS2_LSHIFT) begin
        lshift_next_s = !ev_rel_s;
      end else if (ev_code_s == PS2_RSHIFT) begin
        rshift_next_s = !ev_rel_s;
      end else if ((ev_code_s == PS2_CAPS) && !ev_rel_s) begin
        caps_next_s = !caps_r;
      end else begin
        caps_next_s = caps_r;
      end
    end else begin
      caps_next_s = caps_r;
    end
  end

  assign shift_next_s = lshift_next_s | rshift_next_s;

`ifdef PS2_ASCII_EN
  ps2_ascii_lut u_lut (
    .code  (ev_code_s),
    .upper (shift_next_s ^ caps_next_s),
    .shift (shift_next_s),
    .ascii (lut_ascii_s)
  );
`else
  assign lut_ascii_s = 8'h00;
`endif

  assign ascii_next_s = (ev_rel_s || ev_ext_s) ? 8'h00 : lut_ascii_s;

  // Registered event fields and modifier levels; fields hold between events.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid_r <= 1'b0;
      key_code_r  <= 8'h00;
      key_ext_r   <= 1'b0;
      key_rel_r   <= 1'b0;
      ascii_r     <= 8'h00;
      err_r       <= 1'b0;
      held_r      <= 10'd0;
      lshift_r    <= 1'b0;
      rshift_r    <= 1'b0;
      shift_r     <= 1'b0;
      caps_r      <= 1'b0;
    end else begin
      key_valid_r <= emit_s;
      err_r       <= err_s;
      held_r      <= held_next_s;
      lshift_r    <= lshift_next_s;
      rshift_r    <= rshift_next_s;
      shift_r     <= shift_next_s;
      caps_r      <= caps_next_s;
      if (emit_s) begin
        key_code_r <= ev_code_s;
        key_ext_r  <= ev_ext_s;
        key_rel_r  <= ev_rel_s;
        ascii_r    <= ascii_next_s;
      end
    end
  end

  assign key_valid    = key_valid_r;
  assign key_code     = key_code_r;
  assign key_extended = key_ext_r;
  assign key_release  = key_rel_r;
  assign ascii        = ascii_r;
  assign shift        = shift_r;
  assign caps         = caps_r;
  assign err          = err_r;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder: directed self-checking bench for ps2_scan_decoder.
module tb_ps2_scan_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;
  logic       key_valid, key_extended, key_release, shift, caps, err;
  logic [7:0] key_code, ascii;

  int n_checks = 0;
  int n_fail   = 0;
  int ev_cnt   = 0;
  int ev_base  = 0;
  int err_cnt  = 0;

`ifdef PS2_ASCII_EN
  localparam logic [7:0] ASC_LA = 8'h61;
  localparam logic [7:0] ASC_UA = 8'h41;
  localparam logic [7:0] ASC_US = 8'h53;
`else
  localparam logic [7:0] ASC_LA = 8'h00;
  localparam logic [7:0] ASC_UA = 8'h00;
  localparam logic [7:0] ASC_US = 8'h00;
`endif

  ps2_scan_decoder #(.DROP_REPEAT(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .code_valid   (code_valid),
    .code         (code),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_extended (key_extended),
    .key_release  (key_release),
    .shift        (shift),
    .caps         (caps),
    .ascii        (ascii),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Count event and error pulses once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (key_valid === 1'b1) ev_cnt = ev_cnt + 1;
    if (err === 1'b1) err_cnt = err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code_valid = 1'b1;
    code = b;
  endtask

  task automatic idle();
    @(negedge clk);
    code_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    code_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_code", key_code, 8'h00);
    chk("rst_fields", {key_extended, key_release, shift, caps, err}, 5'b0);
    chk("rst_ascii", ascii, 8'h00);

    // Plain make of 'a'.
    ev_base = ev_cnt;
    send(8'h1C); idle();
    chk("a_valid", key_valid, 1'b1);
    chk("a_code", key_code, 8'h1C);
    chk("a_flags", {key_release, key_extended}, 2'b00);
    chk("a_ascii", ascii, ASC_LA);
    idle();
    chk("a_pulse", key_valid, 1'b0);
    chk("a_hold", key_code, 8'h1C);
    chk("a_count", ev_cnt - ev_base, 1);

    // Shifted 'A' and shift release.
    send(8'h12); idle();
    chk("lsh_valid", key_valid, 1'b1);
    chk("lsh_shift", shift, 1'b1);
    chk("lsh_code", key_code, 8'h12);
    send(8'h1C); idle();
    chk("A_ascii", ascii, ASC_UA);
    chk("A_shift", shift, 1'b1);
    send(8'hF0); send(8'h1C); idle();
    chk("brk_a", {key_valid, key_release, key_code}, {2'b11, 8'h1C});
    chk("brk_a_ascii", ascii, 8'h00);
    send(8'hF0); send(8'h12); idle();
    chk("brk_lsh", {key_valid, key_release, key_code}, {2'b11, 8'h12});
    chk("brk_lsh_shift", shift, 1'b0);

    // Extended make and break, one-cycle latency.
    send(8'hE0); send(8'h75); #1;
    chk("ext_early", key_valid, 1'b0);
    idle();
    chk("ext_make", {key_valid, key_extended, key_release, key_code}, {3'b110, 8'h75});
    send(8'hE0); send(8'hF0); send(8'h75); idle();
    chk("ext_brk", {key_valid, key_extended, key_release, key_code}, {3'b111, 8'h75});

    // Typematic repeats dropped; caps toggles once.
    ev_base = ev_cnt;
    send(8'h1C); send(8'h1C); send(8'h1C); idle(); idle();
    chk("rep_count", ev_cnt - ev_base, 1);
    ev_base = ev_cnt;
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58); idle(); idle();
    chk("caps_level", caps, 1'b1);
    chk("caps_count", ev_cnt - ev_base, 2);

    // Pause sequence yields one event, then normal decode resumes.
    ev_base = ev_cnt;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); #1;
    chk("pause_quiet", ev_cnt - ev_base, 0);
    send(8'h77); idle();
    chk("pause_ev", {key_valid, key_extended, key_release, key_code}, {3'b100, 8'hE1});
    chk("pause_count", ev_cnt - ev_base, 1);
    send(8'h1C); idle();
    chk("post_pause", {key_valid, key_code}, {1'b1, 8'h1C});
    chk("post_pause_ascii", ascii, ASC_UA);

    // Protocol error F0 E0 returns to IDLE without an event.
    ev_base = ev_cnt;
    send(8'hF0); send(8'hE0); idle();
    chk("err_pulse", {err, key_valid}, 2'b10);
    idle();
    chk("err_clear", err, 1'b0);
    chk("err_noev", ev_cnt - ev_base, 0);
    send(8'h1B); idle();
    chk("err_idle", {key_valid, key_extended, key_code}, {2'b10, 8'h1B});
    chk("err_idle_ascii", ascii, ASC_US);
    ev_base = err_cnt;
    send(8'h00); idle(); idle();
    chk("err_00", err_cnt - ev_base, 1);

    // Reset mid-sequence drops the E0 prefix and clears caps.
    send(8'hE0);
    do_reset();
    send(8'h75); idle();
    chk("rst_mid", {key_valid, key_extended, key_code}, {2'b10, 8'h75});
    chk("rst_mid_caps", caps, 1'b0);

    // Reset wins over a simultaneous byte.
    ev_base = ev_cnt;
    @(negedge clk);
    reset = 1'b1; code_valid = 1'b1; code = 8'h1C;
    @(negedge clk);
    reset = 1'b0; code_valid = 1'b0;
    idle(); idle();
    chk("rst_wins", ev_cnt - ev_base, 0);
    chk("rst_wins_code", key_code, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
